// File: rtl/tdm_demux_1x8.sv
// Receive side of the 8:1 TDM link: tracks the slot counter, steers each
// accepted word into its lane and publishes whole frames with a valid pulse.
module tdm_demux_1x8 #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               din_valid,
   input  logic [WIDTH-1:0]   din,
   input  logic               sof,
   output logic [8*WIDTH-1:0] out,
   output logic               frame_valid,
   output logic               sync_err,
   output logic [2:0]         slot,
   output logic               locked
);

   typedef enum logic {HUNT, RUN} state_t;

   state_t                 state, state_n;
   logic [2:0]             slot_n;
   logic [2:0]             wr_idx;
   logic                   wr;
   logic                   fire;
   logic                   resync;
   // Lane 7 is never stored: its word goes straight to out with the frame.
   logic [6:0][WIDTH-1:0]  shadow;

   always_comb begin
      state_n = state;
      slot_n  = slot;
      wr      = 1'b0;
      wr_idx  = slot;
      fire    = 1'b0;
      resync  = 1'b0;
      case (state)
         HUNT: begin
            if (din_valid && sof) begin
               state_n = RUN;
               wr      = 1'b1;
               wr_idx  = 3'd0;
               slot_n  = 3'd1;
            end
         end
         RUN: begin
            if (din_valid) begin
               if (sof && slot != 3'd0) begin
                  resync = 1'b1;
                  wr     = 1'b1;
                  wr_idx = 3'd0;
                  slot_n = 3'd1;
               end else begin
                  wr     = 1'b1;
                  slot_n = slot + 3'd1;
                  fire   = (slot == 3'd7);
               end
            end
         end
         default: state_n = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         slot        <= 3'd0;
         locked      <= 1'b0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         out         <= '0;
      end else begin
         state       <= state_n;
         slot        <= slot_n;
         locked      <= (state_n == RUN);
         frame_valid <= fire;
         sync_err    <= resync;
         if (fire)
            out <= {din, shadow};
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 7; i++) begin
         if (rst)
            shadow[i] <= '0;
         else if (wr && wr_idx == 3'(i))
            shadow[i] <= din;
      end
   end

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed bench for tdm_demux_1x8: a queue-based frame model checked every
// cycle, plus literal frame/timing expectations per scenario.
module tb_tdm_demux_1x8;
   localparam int W = 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           din_valid = 1'b0;
   logic [W-1:0]   din = '0;
   logic           sof = 1'b0;
   logic [8*W-1:0] out;
   logic           frame_valid;
   logic           sync_err;
   logic [2:0]     slot;
   logic           locked;

   tdm_demux_1x8 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .sof(sof),
      .out(out), .frame_valid(frame_valid), .sync_err(sync_err),
      .slot(slot), .locked(locked)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // Model: the partial frame is just the list of words received since slot 0.
   logic [W-1:0]   frame_q[$];
   logic           m_lock = 1'b0;
   logic [8*W-1:0] m_out = '0;
   logic           m_fv = 1'b0;
   logic           m_se = 1'b0;

   // Observations for the literal checks.
   logic [8*W-1:0] fv_outs[$];
   int             fv_cycs[$];
   int             se_count = 0;
   int             start_cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      m_fv = 1'b0;
      m_se = 1'b0;
      if (rst) begin
         m_lock = 1'b0;
         frame_q.delete();
         m_out = '0;
      end else if (din_valid) begin
         if (m_lock && sof && frame_q.size() != 0) begin
            m_se = 1'b1;
            frame_q.delete();
         end
         if (m_lock || sof) begin
            m_lock = 1'b1;
            frame_q.push_back(din);
            if (frame_q.size() == 8) begin
               for (int i = 0; i < 8; i++) m_out[i*W +: W] = frame_q[i];
               m_fv = 1'b1;
               frame_q.delete();
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("out", 64'(out), 64'(m_out));
         chk("frame_valid", 64'(frame_valid), 64'(m_fv));
         chk("sync_err", 64'(sync_err), 64'(m_se));
         chk("slot", 64'(slot), 64'(frame_q.size() % 8));
         chk("locked", 64'(locked), 64'(m_lock));
         if (frame_valid === 1'b1) begin
            fv_outs.push_back(out);
            fv_cycs.push_back(cyc);
         end
         if (sync_err === 1'b1) se_count++;
      end
   end

   task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
      din_valid = v;
      sof       = s;
      din       = d;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, '0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, '0);
      rst = 1'b0;
   endtask

   // Beat i carries bit i of the frame byte; gap inserted after beat gap_after.
   task automatic send_frame(input logic [7:0] b, input int gap_after, input int gap_len);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, i == 0, b[i]);
         if (i == 0) start_cyc = cyc;
         if (i == gap_after) idle(gap_len);
      end
   endtask

   task automatic clear_obs();
      fv_outs.delete();
      fv_cycs.delete();
      se_count = 0;
   endtask

   int rel1;
   int rel2;

   initial begin
      do_reset();
      chk_en = 1'b1;
      chk("reset out", 64'(out), 64'h0);
      chk("reset locked", 64'(locked), 64'h0);
      chk("reset slot", 64'(slot), 64'h0);

      // 1: single frame
      clear_obs();
      drive(1'b1, 1'b1, 1'b1);
      start_cyc = cyc;
      chk("t1 locked after first beat", 64'(locked), 64'h1);
      drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      idle(2);
      chk("t1 fv count", 64'(fv_outs.size()), 64'd1);
      if (fv_outs.size() == 1) begin
         chk("t1 out", 64'(fv_outs[0]), 64'hAD);
         rel1 = fv_cycs[0] - start_cyc;
         chk("t1 latency", 64'(rel1), 64'd7);
      end
      chk("t1 slot after", 64'(slot), 64'h0);

      // 2: gap of 3 after the 4th beat
      clear_obs();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, i == 0, 1'((8'hAD >> i) & 8'h1));
         if (i == 0) start_cyc = cyc;
         if (i == 3) begin
            idle(3);
            chk("t2 slot in gap", 64'(slot), 64'd4);
         end
      end
      idle(2);
      chk("t2 fv count", 64'(fv_outs.size()), 64'd1);
      if (fv_outs.size() == 1) begin
         chk("t2 out", 64'(fv_outs[0]), 64'hAD);
         rel2 = fv_cycs[0] - start_cyc;
         chk("t2 delay vs t1", 64'(rel2 - rel1), 64'd3);
      end

      // 3: HUNT drops beats until sof
      do_reset();
      clear_obs();
      repeat (5) drive(1'b1, 1'b0, 1'b1);
      chk("t3 hunt locked", 64'(locked), 64'h0);
      chk("t3 hunt slot", 64'(slot), 64'h0);
      send_frame(8'hAD, -1, 0);
      idle(2);
      chk("t3 fv count", 64'(fv_outs.size()), 64'd1);
      if (fv_outs.size() == 1) chk("t3 out", 64'(fv_outs[0]), 64'hAD);
      chk("t3 no sync_err", 64'(se_count), 64'd0);

      // 4: resync mid-frame
      clear_obs();
      drive(1'b1, 1'b1, 1'b1);
      repeat (3) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      repeat (7) drive(1'b1, 1'b0, 1'b1);
      idle(2);
      chk("t4 sync_err count", 64'(se_count), 64'd1);
      chk("t4 fv count", 64'(fv_outs.size()), 64'd1);
      if (fv_outs.size() == 1) chk("t4 out", 64'(fv_outs[0]), 64'hFE);

      // 5: back-to-back frames, sof only on the first beat
      clear_obs();
      send_frame(8'h5A, -1, 0);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'((8'hC3 >> i) & 8'h1));
      idle(2);
      chk("t5 fv count", 64'(fv_outs.size()), 64'd2);
      if (fv_outs.size() == 2) begin
         chk("t5 out first", 64'(fv_outs[0]), 64'h5A);
         chk("t5 out second", 64'(fv_outs[1]), 64'hC3);
         chk("t5 spacing", 64'(fv_cycs[1] - fv_cycs[0]), 64'd8);
      end

      // 6: reset mid-frame after a completed frame
      send_frame(8'hAD, -1, 0);
      idle(1);
      chk("t6 pre out", 64'(out), 64'hAD);
      clear_obs();
      drive(1'b1, 1'b1, 1'b1);
      repeat (4) drive(1'b1, 1'b0, 1'b1);
      do_reset();
      chk("t6 rst out", 64'(out), 64'h0);
      chk("t6 rst locked", 64'(locked), 64'h0);
      chk("t6 rst slot", 64'(slot), 64'h0);
      repeat (7) drive(1'b1, 1'b0, 1'b1);
      idle(2);
      chk("t6 tail fv count", 64'(fv_outs.size()), 64'd0);
      chk("t6 tail locked", 64'(locked), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
